// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_types;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_ALLOC_REQ,
    S_ALLOC_DATA,
    S_FILL
  } icache_state_t;

  typedef logic [255:0] line_t;

  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  function automatic logic [31:0] word_sel(input line_t line, input logic [2:0] off);
    return line[{off, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Line storage: one full-line write port, one combinational read port, no reset.
module icache_data_array #(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int IDX_W     = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [LINE_BITS-1:0] rd_line
);

  logic [LINE_BITS-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_line;
  end

  assign rd_line = mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-beat 64-bit line refill.
module icache
  import icache_types::*;
#(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

  icache_state_t state_q, state_d;

  logic [31:2]          req_addr_p0;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           off;
  logic [TAG_W-1:0]     tag_mem [SETS];
  logic [SETS-1:0]      valid_q;
  logic [1:0]           beat_cnt;
  line_t                line_buf;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit;
  logic                 load_req;
  logic                 unused_bits;

  assign unused_bits = ^imem_addr[1:0];

  assign idx = req_addr_p0[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
  assign tag = req_addr_p0[31:OFFSET_BITS+IDX_W];
  assign off = req_addr_p0[4:2];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  icache_data_array #(
    .SETS      (SETS),
    .LINE_BITS (LINE_BITS),
    .IDX_W     (IDX_W)
  ) u_data (
    .clk     (clk),
    .we      (state_q == S_FILL),
    .wr_idx  (idx),
    .wr_line (line_buf),
    .rd_idx  (idx),
    .rd_line (rd_line)
  );

  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|imem_rmask) begin
          load_req = 1'b1;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          if (|imem_rmask) load_req = 1'b1;
          else             state_d  = S_IDLE;
        end else begin
          state_d = S_ALLOC_REQ;
        end
      end
      S_ALLOC_REQ: begin
        if (bmem_ready) state_d = S_ALLOC_DATA;
      end
      S_ALLOC_DATA: begin
        if (bmem_rvalid && (beat_cnt == 2'(BEATS - 1))) state_d = S_FILL;
      end
      S_FILL:  state_d = S_COMPARE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: only these registers see reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FILL) valid_q[idx] <= 1'b1;
      if (state_q == S_ALLOC_DATA && bmem_rvalid) beat_cnt <= beat_cnt + 2'd1;
    end
  end

  // Request capture, beat assembly and tag write
  always_ff @(posedge clk) begin
    if (load_req) req_addr_p0 <= imem_addr[31:2];
    if (state_q == S_ALLOC_DATA && bmem_rvalid) line_buf[{beat_cnt, 6'b000000} +: 64] <= bmem_rdata;
    if (state_q == S_FILL) tag_mem[idx] <= tag;
  end

  assign imem_resp  = (state_q == S_COMPARE) && hit;
  assign imem_rdata = imem_resp ? word_sel(line_t'(rd_line), off) : '0;
  assign bmem_read  = (state_q == S_ALLOC_REQ);
  assign bmem_addr  = bmem_read ? {req_addr_p0[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: transparent-memory model plus literal timing/data checks.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  icache #(.SETS(16), .LINE_BITS(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int samp  = 0;
  int resp_cnt = 0;
  int acc_cnt  = 0;
  int beats_sent = 0;
  int ready_lat = 0;
  int beat_gap  = 0;
  logic slave_busy = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_line_q[$];
  logic [31:0] model_line [16];

  // Backing memory: line 0x40 holds the 0x1111../0x2222../0x3333../0x4444.. beats
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [3:0] nib;
    if ({a[31:5], 5'b0} == 32'h40) begin
      nib = {2'b00, a[4:3]} + 4'd1;
      return {8{nib}};
    end
    return {a[31:2], 2'b00} * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] line, input int k);
    return {mem_word(line + 32'(8 * k + 4)), mem_word(line + 32'(8 * k))};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Direct-mapped contents model: a fetch refills iff its line is not the one resident in its set
  task automatic push_req(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    if (model_line[a[8:5]] != la) begin
      exp_line_q.push_back(la);
      model_line[a[8:5]] = la;
    end
    exp_q.push_back(mem_word(a));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_line[i] = 32'hFFFF_FFFF;
    exp_q.delete();
    exp_line_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    imem_addr  = a;
    imem_rmask = 4'hF;
    push_req(a);
    step();
    samp = cyc;
    imem_rmask = 4'h0;
  endtask

  task automatic wait_resp(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (imem_resp) begin
        seen = 1'b1;
        lat  = cyc - samp + 1;
      end else begin
        step();
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got none expected resp within 80 cycles");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp"},  imem_resp,  1'b0);
    chk({tag, "_rdata"}, imem_rdata, 32'h0);
    chk({tag, "_read"},  bmem_read,  1'b0);
    chk({tag, "_baddr"}, bmem_addr,  32'h0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Burst memory responder
  initial begin
    logic [31:0] bl;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
    forever begin
      step();
      if (bmem_read && rst_n) begin
        slave_busy = 1'b1;
        for (int i = 0; i < ready_lat; i++) step();
        bmem_ready = 1'b1;
        bl = bmem_addr;
        step();
        bmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          for (int g = 0; g < beat_gap; g++) step();
          bmem_rvalid = 1'b1;
          bmem_rdata  = beat_of(bl, k);
          @(posedge clk);
          beats_sent++;
          #1;
          bmem_rvalid = 1'b0;
        end
        slave_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (imem_resp) begin
        resp_cnt++;
        chk("resp_outside_refill", bmem_read, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_resp: got rdata %0h expected no response", imem_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", imem_rdata, e);
        end
      end
      if (bmem_read) begin
        if (exp_line_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_refill: got bmem_addr %0h expected no bmem_read", bmem_addr);
        end else begin
          chk("refill_addr", bmem_addr, exp_line_q[0]);
          if (bmem_ready) begin
            void'(exp_line_q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, a0, r0;
    logic got;
    rst_n      = 1'b0;
    imem_addr  = '0;
    imem_rmask = 4'h0;
    model_reset();

    step();
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_resp", imem_resp, 1'b0);

    // Cold miss on 0x40
    ready_lat = 0;
    beat_gap  = 0;
    a0 = acc_cnt;
    issue(32'h40);
    wait_resp(lat);
    chk("cold_latency", lat, 8);
    chk("cold_data", imem_rdata, 32'h1111_1111);
    chk("cold_refills", acc_cnt - a0, 1);
    step();

    // Back-to-back hits
    a0 = acc_cnt;
    imem_addr  = 32'h44;
    imem_rmask = 4'hF;
    push_req(32'h44);
    step();
    chk("b2b_resp0", imem_resp, 1'b1);
    chk("b2b_data0", imem_rdata, 32'h1111_1111);
    imem_addr = 32'h48;
    push_req(32'h48);
    step();
    chk("b2b_resp1", imem_resp, 1'b1);
    chk("b2b_data1", imem_rdata, 32'h2222_2222);
    imem_addr = 32'h5C;
    push_req(32'h5C);
    step();
    chk("b2b_resp2", imem_resp, 1'b1);
    chk("b2b_data2", imem_rdata, 32'h4444_4444);
    imem_rmask = 4'h0;
    step();
    chk("b2b_after", imem_resp, 1'b0);
    chk("b2b_refills", acc_cnt - a0, 0);

    // Conflict eviction in set 2
    a0 = acc_cnt;
    issue(32'h240);
    wait_resp(lat);
    chk("conflict_refill", acc_cnt - a0, 1);
    step();
    issue(32'h40);
    wait_resp(lat);
    chk("refetch_refill", acc_cnt - a0, 2);
    chk("refetch_data", imem_rdata, 32'h1111_1111);
    step();

    // Backpressure and gapped beats
    ready_lat = 5;
    beat_gap  = 2;
    a0 = acc_cnt;
    r0 = resp_cnt;
    issue(32'h3A4);
    wait_resp(lat);
    chk("bp_latency", lat, 8 + 5 + 4 * 2);
    repeat (6) step();
    chk("bp_resp_once", resp_cnt - r0, 1);
    chk("bp_refills", acc_cnt - a0, 1);

    // Reset in the middle of a refill
    ready_lat  = 0;
    beat_gap   = 1;
    beats_sent = 0;
    issue(32'h128);
    for (int i = 0; i < 40 && beats_sent < 2; i++) step();
    chk("rst_beats_before", beats_sent, 2);
    rst_n = 1'b0;
    model_reset();
    step();
    chk_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40 && slave_busy; i++) step();
    chk("rst_slave_drained", slave_busy, 1'b0);
    step();
    a0 = acc_cnt;
    issue(32'h128);
    wait_resp(lat);
    chk("rst_refill", acc_cnt - a0, 1);
    chk("rst_latency", lat, 8 + 4);
    step();

    // Address churn while refilling 0x100
    ready_lat  = 1;
    beat_gap   = 1;
    imem_addr  = 32'h100;
    imem_rmask = 4'hF;
    push_req(32'h100);
    step();
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (imem_resp) begin
        chk("churn_data", imem_rdata, mem_word(32'h100));
        imem_addr = 32'h104;
        push_req(32'h104);
        got = 1'b1;
      end else begin
        imem_addr = 32'h800 + 32'(i * 4);
      end
      step();
    end
    imem_rmask = 4'h0;
    chk("churn_resp_seen", got, 1'b1);
    chk("churn_next_resp", imem_resp, 1'b1);
    chk("churn_next_data", imem_rdata, mem_word(32'h104));

    repeat (3) step();
    chk("exp_drained", exp_q.size(), 0);
    chk("refill_drained", exp_line_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache sitting between the CPU fetch port (`imem_*`) and the burst memory interface (`bmem_*`). It answers fetch hits one cycle after the request is sampled. On a miss it refills a full cache line with a fixed-length 64-bit burst, then serves the request. It replaces the zero-latency instruction memory model at the CPU boundary without changing the CPU's `imem_*` handshake.

## Interface
- `SETS`, default 16: number of lines, power of two, ≥2.
- `LINE_BITS`, default 256: line size; fixed at 256 (8 words, 4 beats of 64 bits).
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_addr` in 32: fetch byte address; bits [1:0] ignored.
- `imem_rmask` in 4: request valid when nonzero; the mask value is otherwise ignored (full word is always returned).
- `imem_rdata` out 32: fetched word; valid only when `imem_resp`=1.
- `imem_resp` out 1: one-cycle pulse; completes the oldest sampled request.
- `bmem_addr` out 32: line-aligned refill address (bits [4:0]=0).
- `bmem_read` out 1: refill request; held until accepted.
- `bmem_ready` in 1: accept; request is taken on a cycle with `bmem_read`=1 and `bmem_ready`=1.
- `bmem_rdata` in 64: burst beat data.
- `bmem_rvalid` in 1: beat valid; exactly 4 beats per accepted read, in ascending address order, possibly non-contiguous.

## Operation
- Address split: offset [4:2] word-in-line, index [4+log2(SETS):5], tag = remaining upper bits.
- Storage: per set a valid bit, a tag, and a 256-bit line. All valid bits are cleared by reset; tag and data are not reset.
- States:
  - IDLE: no request pending.
  - COMPARE: request registered, tag check.
  - ALLOC_REQ: `bmem_read` asserted.
  - ALLOC_DATA: collecting beats.
  - FILL: write line, set valid.
- IDLE/COMPARE: when `imem_rmask`≠0, register `imem_addr` → COMPARE.
- COMPARE hit: `imem_resp`=1 with the selected word.
  - If a new request is present that cycle, register it and stay in COMPARE (back-to-back hits); else → IDLE.
- COMPARE miss → ALLOC_REQ.
- ALLOC_REQ: drive `bmem_addr`={tag,index,5'b0} and `bmem_read`=1 until `bmem_ready` → ALLOC_DATA.
- ALLOC_DATA: a 2-bit beat counter; beat k fills bits [64k+63:64k]. After beat 3 → FILL.
- FILL: write line and tag, set valid → COMPARE on the same held request. It hits, so `imem_resp` fires the next cycle.
- `imem_addr` changes while not in IDLE/COMPARE are ignored. The registered request is the one answered.
- `bmem_rvalid` outside ALLOC_DATA is dropped (stale beats after reset).
- Reset at any state: → IDLE, valids cleared, `bmem_read`=0, beat counter=0.

## Timing
- Reset values:
  - `imem_resp`=0, `imem_rdata`=0, `bmem_read`=0, `bmem_addr`=0.
- Hit latency: request sampled at edge N, `imem_resp` high during cycle N+1. Full throughput is one hit per cycle.
- Miss latency from sampling edge:
  - 1 (COMPARE)
  - + ≥1 (ALLOC_REQ, until accept)
  - + beat cycles
  - + 1 (FILL)
  - + 1 (COMPARE, resp).
  - Minimum with `bmem_ready` stuck at 1 and contiguous beats: `imem_resp` at cycle N+8.
- `bmem_read` is deasserted the cycle after acceptance. There is never more than one outstanding refill.
- `imem_resp` is never high in ALLOC_REQ, ALLOC_DATA or FILL.

## Structure
- `icache_types` package:
  - state enum `icache_state_t`
  - `line_t` (logic [255:0])
  - `BEATS`=4 and `OFFSET_BITS`=5 constants.
- Sub-module `icache_data_array`:
  - `SETS`×256-bit register array, one line-wide write port, one combinational read port.
- Tag and valid arrays, FSM, and beat counter live in `icache`.

## Test plan
- Cold miss: reset, fetch 0x0000_0040 with `bmem_ready`=1.
  - `bmem_read` with `bmem_addr`=0x0000_0040.
  - Beats 0x1111…, 0x2222…, 0x3333…, 0x4444… → `imem_resp` at cycle 8 with `imem_rdata`=low word of beat 0.
- Back-to-back hits: after the fill, fetch 0x44, 0x48, 0x5C on consecutive cycles.
  - Three consecutive `imem_resp` pulses.
  - Words come from beat 0 high, beat 1 low, and beat 3 high respectively.
  - No `bmem_read`.
- Conflict eviction: fetch 0x0000_0040 then 0x0000_0240 (same index, SETS=16).
  - Second fetch refills.
  - Refetch of 0x40 misses again.
- Backpressure and gapped beats: `bmem_ready` low for 5 cycles, beats with 2-cycle gaps.
  - `bmem_read` is held stable with a constant address.
  - Correct word is returned.
  - `imem_resp` appears exactly once.
- Reset mid-refill: assert `rst_n`=0 after beat 1, then release.
  - Outputs return to reset values.
  - The remaining 2 beats are ignored.
  - Refetch of the same address misses and refills.
- Address churn during miss: change `imem_addr` every cycle during refill of 0x100.
  - Response is for 0x100.
  - The next sampled request is handled afterwards.
